// File: rtl/dmem_responder.sv
// Byte-addressable data memory responder with a fixed number of wait states per access.
// Latency: response in RESP, WAIT_CYCLES+1 edges after acceptance; busy (req_ready=0) until RESP ends.
// Backpressure: one request in flight; req_ready is high only in IDLE.
module dmem_responder #(
    parameter int DM_ADDRESS  = 9,
    parameter int DATA_W      = 32,
    parameter int WAIT_CYCLES = 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  MemRead,
    input  logic                  MemWrite,
    input  logic [DM_ADDRESS-1:0] a,
    input  logic [DATA_W-1:0]     wd,
    input  logic [2:0]            Funct3,
    output logic                  resp_valid,
    output logic [DATA_W-1:0]     rd,
    output logic                  resp_err
);
    localparam int WORDS = 2 ** (DM_ADDRESS - 2);
    localparam int CNT_W = (WAIT_CYCLES > 0) ? $clog2(WAIT_CYCLES + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(WAIT_CYCLES);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

    state_t                state_q, state_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [DM_ADDRESS-1:0] addr_q, addr_d;
    logic [DATA_W-1:0]     wdat_q, wdat_d;
    logic [2:0]            f3_q, f3_d;
    logic                  rden_q, rden_d;
    logic                  wren_q, wren_d;

    logic [31:0]           mem_q [WORDS];

    // In IDLE the request being accepted is still on the inputs; afterwards the captured copy rules.
    logic [DM_ADDRESS-1:0] cur_addr;
    logic [DATA_W-1:0]     cur_wd;
    logic [2:0]            cur_f3;
    logic                  cur_rd, cur_wr, cur_err;
    logic [1:0]            lane;
    logic [3:0]            be;
    logic [31:0]           wr_word;
    logic                  commit;
    logic [31:0]           ld_word, ld_shift, ld_ext;

    always_comb begin
        if (state_q == IDLE) begin
            cur_addr = a;
            cur_wd   = wd;
            cur_f3   = Funct3;
            cur_rd   = MemRead;
            cur_wr   = MemWrite;
        end else begin
            cur_addr = addr_q;
            cur_wd   = wdat_q;
            cur_f3   = f3_q;
            cur_rd   = rden_q;
            cur_wr   = wren_q;
        end
    end

    assign lane = cur_addr[1:0];

    always_comb begin
        cur_err = (cur_rd == cur_wr);
        case (cur_f3)
            3'b000:  ;
            3'b001:  if (cur_addr[0]) cur_err = 1'b1;
            3'b010:  if (cur_addr[1:0] != 2'b00) cur_err = 1'b1;
            3'b100:  if (cur_wr) cur_err = 1'b1;
            3'b101:  if (cur_wr || cur_addr[0]) cur_err = 1'b1;
            default: cur_err = 1'b1;
        endcase
    end

    always_comb begin
        be      = 4'b0000;
        wr_word = 32'h0;
        case (cur_f3[1:0])
            2'b00: begin
                be      = 4'b0001 << lane;
                wr_word = {4{cur_wd[7:0]}};
            end
            2'b01: begin
                be      = 4'b0011 << lane;
                wr_word = {2{cur_wd[15:0]}};
            end
            default: begin
                be      = 4'b1111;
                wr_word = cur_wd;
            end
        endcase
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        wdat_d  = wdat_q;
        f3_d    = f3_q;
        rden_d  = rden_q;
        wren_d  = wren_q;
        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    addr_d = a;
                    wdat_d = wd;
                    f3_d   = Funct3;
                    rden_d = MemRead;
                    wren_d = MemWrite;
                    if (WAIT_CYCLES > 0) begin
                        state_d = ACCESS;
                        cnt_d   = CNT_INIT;
                    end else begin
                        state_d = RESP;
                    end
                end
            end
            ACCESS: begin
                if (cnt_q <= CNT_ONE) begin
                    state_d = RESP;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q - CNT_ONE;
                end
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            addr_q  <= '0;
            wdat_q  <= '0;
            f3_q    <= '0;
            rden_q  <= 1'b0;
            wren_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            wdat_q  <= wdat_d;
            f3_q    <= f3_d;
            rden_q  <= rden_d;
            wren_q  <= wren_d;
        end
    end

    // Storage is deliberately not reset; gating on reset keeps an aborted store from landing.
    assign commit = reset && (state_q != RESP) && (state_d == RESP) && cur_wr && !cur_err;

    always_ff @(posedge clk) begin
        if (commit) begin
            for (int i = 0; i < 4; i++) begin
                if (be[i]) begin
                    mem_q[cur_addr[DM_ADDRESS-1:2]][8*i +: 8] <= wr_word[8*i +: 8];
                end
            end
        end
    end

    assign ld_word  = mem_q[addr_q[DM_ADDRESS-1:2]];
    assign ld_shift = ld_word >> {addr_q[1:0], 3'b000};

    always_comb begin
        case (f3_q)
            3'b000:  ld_ext = {{24{ld_shift[7]}}, ld_shift[7:0]};
            3'b001:  ld_ext = {{16{ld_shift[15]}}, ld_shift[15:0]};
            3'b100:  ld_ext = {24'h0, ld_shift[7:0]};
            3'b101:  ld_ext = {16'h0, ld_shift[15:0]};
            default: ld_ext = ld_word;
        endcase
    end

    assign req_ready  = (state_q == IDLE);
    assign resp_valid = (state_q == RESP);
    assign resp_err   = (state_q == RESP) && cur_err;
    assign rd         = ((state_q == RESP) && rden_q && !cur_err) ? ld_ext : '0;

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench: a WAIT_CYCLES=1 instance runs a vector table; a WAIT_CYCLES=3 instance covers
// dual-command errors and held req_valid; a reset abort sequence closes the run.
module tb_dmem_responder;
    logic        clk = 1'b0;
    logic        reset;
    logic        rv1, rv3, mr, mw;
    logic [2:0]  f3;
    logic [8:0]  addr;
    logic [31:0] wdat;
    logic        rdy1, rdy3, vld1, vld3, err1, err3;
    logic [31:0] rd1, rd3;
    logic        sel;
    logic        c_rdy, c_vld, c_err;
    logic [31:0] c_rd;

    int pass_cnt = 0;
    int total_cnt = 0;

    always #5 clk = ~clk;

    dmem_responder #(.DM_ADDRESS(9), .DATA_W(32), .WAIT_CYCLES(1)) u_dut1 (
        .clk(clk), .reset(reset), .req_valid(rv1), .req_ready(rdy1),
        .MemRead(mr), .MemWrite(mw), .a(addr), .wd(wdat), .Funct3(f3),
        .resp_valid(vld1), .rd(rd1), .resp_err(err1)
    );

    dmem_responder #(.DM_ADDRESS(9), .DATA_W(32), .WAIT_CYCLES(3)) u_dut3 (
        .clk(clk), .reset(reset), .req_valid(rv3), .req_ready(rdy3),
        .MemRead(mr), .MemWrite(mw), .a(addr), .wd(wdat), .Funct3(f3),
        .resp_valid(vld3), .rd(rd3), .resp_err(err3)
    );

    assign c_rdy = sel ? rdy3 : rdy1;
    assign c_vld = sel ? vld3 : vld1;
    assign c_err = sel ? err3 : err1;
    assign c_rd  = sel ? rd3  : rd1;

    typedef struct {
        logic        r;
        logic        w;
        logic [2:0]  fn;
        logic [8:0]  ad;
        logic [31:0] d;
        logic [31:0] exp_rd;
        logic        exp_err;
    } vec_t;

    vec_t vecs[22];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s actual=%h expected=%h", name, act, exp);
    endtask

    task automatic set_valid(input logic v);
        if (sel) rv3 = v;
        else rv1 = v;
    endtask

    task automatic txn(input logic r, input logic w, input logic [2:0] fn, input logic [8:0] ad,
                       input logic [31:0] d, output logic [31:0] r_rd, output logic r_err,
                       output int edges, output int low);
        int n;
        @(negedge clk);
        mr = r; mw = w; f3 = fn; addr = ad; wdat = d;
        set_valid(1'b1);
        n = 0;
        while (!c_rdy && n < 20) begin
            @(negedge clk);
            n++;
        end
        @(posedge clk);
        edges = 1;
        low = 0;
        @(negedge clk);
        // Scramble the request inputs to prove the captured copy is what gets used.
        set_valid(1'b0);
        mr = ~r; mw = ~w; addr = ~ad; wdat = ~d; f3 = 3'b111;
        while (!c_vld && edges < 40) begin
            if (!c_rdy) low++;
            @(negedge clk);
            edges++;
        end
        if (!c_rdy) low++;
        r_rd  = c_rd;
        r_err = c_err;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] g_rd;
        logic        g_err;
        int          g_edges, g_low;
        int          acc_n, resp_n, err_n, first_acc, last_acc, saw;

        vecs[0]  = '{1'b0, 1'b1, 3'b010, 9'h010, 32'hDEADBEEF, 32'h00000000, 1'b0};
        vecs[1]  = '{1'b1, 1'b0, 3'b010, 9'h010, 32'h0,        32'hDEADBEEF, 1'b0};
        vecs[2]  = '{1'b0, 1'b1, 3'b000, 9'h011, 32'h000000F0, 32'h00000000, 1'b0};
        vecs[3]  = '{1'b1, 1'b0, 3'b000, 9'h011, 32'h0,        32'hFFFFFFF0, 1'b0};
        vecs[4]  = '{1'b1, 1'b0, 3'b100, 9'h011, 32'h0,        32'h000000F0, 1'b0};
        vecs[5]  = '{1'b1, 1'b0, 3'b010, 9'h010, 32'h0,        32'hDEADF0EF, 1'b0};
        vecs[6]  = '{1'b0, 1'b1, 3'b001, 9'h012, 32'h00008001, 32'h00000000, 1'b0};
        vecs[7]  = '{1'b1, 1'b0, 3'b001, 9'h012, 32'h0,        32'hFFFF8001, 1'b0};
        vecs[8]  = '{1'b1, 1'b0, 3'b101, 9'h012, 32'h0,        32'h00008001, 1'b0};
        vecs[9]  = '{1'b1, 1'b0, 3'b010, 9'h013, 32'h0,        32'h00000000, 1'b1};
        vecs[10] = '{1'b0, 1'b1, 3'b001, 9'h011, 32'h00001234, 32'h00000000, 1'b1};
        vecs[11] = '{1'b1, 1'b0, 3'b010, 9'h010, 32'h0,        32'h8001F0EF, 1'b0};
        vecs[12] = '{1'b1, 1'b0, 3'b000, 9'h010, 32'h0,        32'hFFFFFFEF, 1'b0};
        vecs[13] = '{1'b1, 1'b0, 3'b100, 9'h013, 32'h0,        32'h00000080, 1'b0};
        vecs[14] = '{1'b1, 1'b0, 3'b001, 9'h010, 32'h0,        32'hFFFFF0EF, 1'b0};
        vecs[15] = '{1'b0, 1'b1, 3'b100, 9'h010, 32'h0,        32'h00000000, 1'b1};
        vecs[16] = '{1'b1, 1'b0, 3'b011, 9'h010, 32'h0,        32'h00000000, 1'b1};
        vecs[17] = '{1'b0, 1'b0, 3'b010, 9'h010, 32'h0,        32'h00000000, 1'b1};
        vecs[18] = '{1'b1, 1'b0, 3'b010, 9'h010, 32'h0,        32'h8001F0EF, 1'b0};
        vecs[19] = '{1'b0, 1'b1, 3'b010, 9'h014, 32'h11223344, 32'h00000000, 1'b0};
        vecs[20] = '{1'b1, 1'b0, 3'b010, 9'h014, 32'h0,        32'h11223344, 1'b0};
        vecs[21] = '{1'b1, 1'b0, 3'b101, 9'h016, 32'h0,        32'h00001122, 1'b0};

        reset = 1'b0; rv1 = 1'b0; rv3 = 1'b0; sel = 1'b0;
        mr = 1'b0; mw = 1'b0; f3 = 3'b000; addr = '0; wdat = '0;

        @(negedge clk);
        chk("rst_vld1", vld1, 1'b0);
        chk("rst_rd1", rd1, 32'h0);
        chk("rst_err1", err1, 1'b0);
        chk("rst_vld3", vld3, 1'b0);
        repeat (2) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        chk("rst_rdy1", rdy1, 1'b1);
        chk("rst_rdy3", rdy3, 1'b1);

        for (int i = 0; i < 22; i++) begin
            txn(vecs[i].r, vecs[i].w, vecs[i].fn, vecs[i].ad, vecs[i].d, g_rd, g_err, g_edges, g_low);
            chk($sformatf("vec%0d_rd", i), g_rd, vecs[i].exp_rd);
            chk($sformatf("vec%0d_err", i), g_err, vecs[i].exp_err);
            chk($sformatf("vec%0d_edges", i), g_edges, 32'd2);
            chk($sformatf("vec%0d_busy", i), g_low, 32'd2);
        end

        // WAIT_CYCLES=3: dual-command error with full timing.
        sel = 1'b1;
        txn(1'b1, 1'b1, 3'b010, 9'h000, 32'h0, g_rd, g_err, g_edges, g_low);
        chk("dual_rd", g_rd, 32'h0);
        chk("dual_err", g_err, 1'b1);
        chk("dual_edges", g_edges, 32'd4);
        chk("dual_busy", g_low, 32'd4);

        // Held req_valid: one acceptance every WAIT_CYCLES+2 cycles.
        mr = 1'b1; mw = 1'b1; f3 = 3'b010; addr = 9'h000; rv3 = 1'b1;
        acc_n = 0; resp_n = 0; err_n = 0; first_acc = -1; last_acc = -1;
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            if (rdy3) begin
                acc_n++;
                if (first_acc < 0) first_acc = i;
                last_acc = i;
            end
            if (vld3) begin
                resp_n++;
                if (err3) err_n++;
            end
        end
        rv3 = 1'b0;
        chk("held_acc", acc_n, 32'd4);
        chk("held_resp", resp_n, 32'd3);
        chk("held_err", err_n, 32'd3);
        chk("held_span", last_acc - first_acc, 32'd15);
        repeat (6) @(negedge clk);

        // Reset abort of a store in ACCESS.
        sel = 1'b0;
        txn(1'b0, 1'b1, 3'b010, 9'h020, 32'h0, g_rd, g_err, g_edges, g_low);
        chk("pre_sw_err", g_err, 1'b0);
        @(negedge clk);
        mr = 1'b0; mw = 1'b1; f3 = 3'b010; addr = 9'h020; wdat = 32'h12345678; rv1 = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rv1 = 1'b0;
        chk("abort_in_access", rdy1, 1'b0);
        reset = 1'b0;
        saw = 0;
        @(negedge clk);
        if (vld1) saw++;
        reset = 1'b1;
        repeat (4) begin
            @(negedge clk);
            if (vld1) saw++;
        end
        chk("abort_no_resp", saw, 32'd0);
        chk("abort_rdy", rdy1, 1'b1);
        txn(1'b1, 1'b0, 3'b010, 9'h020, 32'h0, g_rd, g_err, g_edges, g_low);
        chk("abort_lw_rd", g_rd, 32'h0);
        chk("abort_lw_err", g_err, 1'b0);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule

// File: doc/dmem_responder.md
DMEM_RESPONDER -- requirements
Module: dmem_responder

Interface
REQ-001 Parameter DM_ADDRESS, default 9, byte-address width; storage is 2**DM_ADDRESS bytes, organised as 32-bit words.
REQ-002 Parameter DATA_W, default 32, data width; only 32 is supported.
REQ-003 Parameter WAIT_CYCLES, default 1, range 0..15; number of wait-state cycles inserted per access.
REQ-004 clk  in  1  single clock; all state updates on its rising edge.
REQ-005 reset  in  1  asynchronous, active-low reset.
REQ-006 req_valid  in  1  the core presents a request this cycle.
REQ-007 req_ready  out  1  the block accepts a request this cycle.
REQ-008 MemRead  in  1  the request is a load.
REQ-009 MemWrite  in  1  the request is a store.
REQ-010 a  in  DM_ADDRESS  byte address.
REQ-011 wd  in  DATA_W  store data, right-aligned.
REQ-012 Funct3  in  3  access size and sign: 000 B, 001 H, 010 W, 100 BU, 101 HU.
REQ-013 resp_valid  out  1  one-cycle pulse: the response is valid.
REQ-014 rd  out  DATA_W  load result, extended to 32 bits.
REQ-015 resp_err  out  1  the request was rejected; qualified by resp_valid.

Function
REQ-016 FSM states: IDLE, ACCESS, RESP.
REQ-017 req_ready is 1 only in IDLE.
REQ-018 A request is accepted on an edge where req_valid=1 and req_ready=1.
  - On acceptance, a, wd, Funct3, MemRead and MemWrite are captured into internal registers.
  - Later changes on these inputs are ignored until the next acceptance.
REQ-019 IDLE transitions on acceptance:
  - to ACCESS if WAIT_CYCLES>0;
  - otherwise to RESP.
  - IDLE holds when there is no acceptance.
REQ-020 ACCESS counts the wait counter down from WAIT_CYCLES.
  - It moves to RESP on the edge where the count reaches 1.
  - The counter is ceil(log2(WAIT_CYCLES+1)) bits wide.
REQ-021 RESP lasts exactly one cycle: resp_valid=1, then return to IDLE.
REQ-022 Latency: resp_valid is high in the cycle that starts WAIT_CYCLES+1 edges after the acceptance edge.
  - Sustained throughput is one request per WAIT_CYCLES+2 cycles.
REQ-023 Byte lanes are little-endian: the byte at address a sits in word a[DM_ADDRESS-1:2], lane a[1:0].
REQ-024 Load data:
  - B and H are sign-extended from bit 7 or bit 15.
  - BU and HU are zero-extended.
  - W returns the full word.
REQ-025 Stores:
  - SB updates one lane, SH two lanes, SW four lanes.
  - Other lanes are unchanged.
  - The write commits on the edge that enters RESP.
REQ-026 A store response has rd=0 and resp_err=0.
REQ-027 An error occurs when any of these holds:
  - MemRead=MemWrite (both set, or neither set);
  - Funct3 is not in the legal set (011, 110, 111, and 100/101 with MemWrite);
  - H/HU with a[0]=1;
  - W with a[1:0]!=0.
REQ-028 On an error:
  - storage is not modified;
  - rd=0 and resp_err=1 during RESP;
  - timing is identical to a legal access.
REQ-029 Outside RESP, rd=0, resp_err=0 and resp_valid=0.
REQ-030 A load issued immediately after a store to the same word returns the newly written data.

Reset
REQ-031 When reset=0, asynchronously:
  - FSM goes to IDLE and the wait counter is cleared;
  - resp_valid=0, resp_err=0, rd=0, and req_ready=1 once reset is released.
REQ-032 Reset asserted during ACCESS or RESP aborts the request.
  - An uncommitted store is not written.
  - No response is issued for the aborted request.
REQ-033 Reset does not clear storage; its contents are undefined until first written.

Verification
REQ-034 WAIT_CYCLES=1: SW a=0x010 wd=0xDEADBEEF, then LW a=0x010.
  - Each resp_valid appears 2 edges after acceptance.
  - The load returns rd=0xDEADBEEF with resp_err=0.
REQ-035 After REQ-034, SB a=0x011 wd=0x000000F0, then:
  - LB a=0x011 returns 0xFFFFFFF0;
  - LBU a=0x011 returns 0x000000F0;
  - LW a=0x010 returns 0xDEADF0EF.
REQ-036 After REQ-035, SH a=0x012 wd=0x00008001, then:
  - LH a=0x012 returns 0xFFFF8001;
  - LHU a=0x012 returns 0x00008001.
REQ-037 LW a=0x013 and SH a=0x011 each give resp_err=1 and rd=0; a following LW a=0x010 is unchanged.
REQ-038 MemRead=MemWrite=1, and held req_valid with WAIT_CYCLES=3:
  - the dual-command request gives an error response;
  - req_ready stays low for 4 cycles after each acceptance.
REQ-039 Pull reset low in the ACCESS cycle of SW a=0x020 wd=0x12345678, after a prior SW of 0 to that address.
  - resp_valid never pulses for the aborted store.
  - A later LW a=0x020 returns 0.
